// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Fibonacci PRBS and its sharing controller.
// Contents: PRBS width and tap mask, single-step function, controller state enum.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 8;

  // Taps at bits 7,5,4,3; the register shifts toward the MSB and feedback enters bit 0.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_t;

  // One PRBS advance.
  function automatic logic [LFSR_W-1:0] lfsr8_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_share_ctrl_if.sv
// Request/grant bus between the PRBS sharing controller and its consumers.
// master: consumer side (drives req, seed_load, seed; receives gnt, rdata, busy)
// slave : controller side
interface lfsr_share_ctrl_if #(
  parameter int unsigned NREQ = 4
);

  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             gnt;
  logic [lfsr_pkg::LFSR_W-1:0] rdata;
  logic                        seed_load;
  logic [lfsr_pkg::LFSR_W-1:0] seed;
  logic                        busy;

  modport master (output req, seed_load, seed, input gnt, rdata, busy);
  modport slave  (input req, seed_load, seed, output gnt, rdata, busy);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin winner select.
// Ports: req (request levels), ptr (highest-priority index),
//        onehot/index (first set req bit at or above ptr, wrapping), any (|req).
module rr_pick #(
  parameter  int unsigned NREQ  = 4,
  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan upward from ptr with wrap; the first set bit wins.
  always_comb begin
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        index        = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/lfsr_share_ctrl.sv
// Owns an 8-bit PRBS register and hands out bytes to NREQ requesters by round robin.
// Ports: CLK, RESETN (async active-low), bus (slave side of lfsr_share_ctrl_if):
//   req in, gnt out (one-cycle one-hot pulse), rdata out (byte sent with gnt),
//   seed_load/seed in (reseed, zero maps to 8'h01), busy out (high in STEP).
module lfsr_share_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned       NREQ     = 4,
  parameter int unsigned       STEPS    = 8,
  parameter logic [LFSR_W-1:0] SEED_RST = 8'h01
) (
  input  logic             CLK,
  input  logic             RESETN,
  lfsr_share_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = 8;

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [LFSR_W-1:0]  rdata_q, rdata_d;
  logic               busy_q, busy_d;

  logic [NREQ-1:0]    win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic [LFSR_W-1:0]  seed_safe;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (win_oh),
    .index  (win_idx),
    .any    (win_any)
  );

  // An all-zero seed would lock the PRBS, so it is replaced by 8'h01.
  assign seed_safe = (bus.seed == '0) ? LFSR_W'(1) : bus.seed;

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.seed_load) begin
          lfsr_d = seed_safe;
        end else if (win_any) begin
          gnt_d   = win_oh;
          rdata_d = lfsr_q;
          lfsr_d  = lfsr8_next(lfsr_q);
          ptr_d   = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
          if (STEPS > 1) begin
            state_d = STEP;
            cnt_d   = CNT_W'(STEPS - 1);
          end
        end
      end
      STEP: begin
        if (bus.seed_load) begin
          lfsr_d  = seed_safe;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          lfsr_d = lfsr8_next(lfsr_q);
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == STEP);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_RST;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Scoreboard bench: dut_a runs STEPS=1, dut_b runs STEPS=8; both share CLK/RESETN.
module tb_lfsr_share_ctrl;

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] rdata;
  } exp_t;

  logic CLK       = 1'b0;
  logic RESETN    = 1'b1;
  logic rst_probe = 1'b0;
  logic done      = 1'b0;
  logic bchk_b    = 1'b0;
  logic ebusy_b   = 1'b0;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  lfsr_share_ctrl_if #(.NREQ(4)) bus_a ();
  lfsr_share_ctrl_if #(.NREQ(4)) bus_b ();

  lfsr_share_ctrl #(.NREQ(4), .STEPS(1), .SEED_RST(8'h01)) dut_a (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus_a)
  );

  lfsr_share_ctrl #(.NREQ(4), .STEPS(8), .SEED_RST(8'h01)) dut_b (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus_b)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic push_a(input logic [3:0] g, input logic [7:0] d);
    exp_t e;
    e.gnt   = g;
    e.rdata = d;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [3:0] g, input logic [7:0] d);
    exp_t e;
    e.gnt   = g;
    e.rdata = d;
    qb.push_back(e);
  endtask

  // Asynchronous reset pulse away from the clock edge, with a mid-cycle output probe.
  task automatic pulse_reset();
    RESETN = 1'b0;
    #1 rst_probe = 1'b1;
    #1 rst_probe = 1'b0;
    cyc();
    cyc();
    RESETN = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever a grant appears.
  initial begin : monitor
    int   ncyc;
    exp_t e;
    ncyc = 0;
    forever begin
      @(negedge CLK or posedge rst_probe);
      if (rst_probe) begin
        chk("rst_gnt_a",   32'(bus_a.gnt),   32'h0);
        chk("rst_rdata_a", 32'(bus_a.rdata), 32'h0);
        chk("rst_busy_a",  32'(bus_a.busy),  32'h0);
        chk("rst_gnt_b",   32'(bus_b.gnt),   32'h0);
        chk("rst_rdata_b", 32'(bus_b.rdata), 32'h0);
        chk("rst_busy_b",  32'(bus_b.busy),  32'h0);
      end else begin
        ncyc++;
        if (bus_a.gnt != 4'b0000) begin
          if (qa.size() == 0) begin
            chk("unexpected_gnt_a", 32'(bus_a.gnt), 32'h0);
          end else begin
            e = qa.pop_front();
            chk("gnt_a",   32'(bus_a.gnt),   32'(e.gnt));
            chk("rdata_a", 32'(bus_a.rdata), 32'(e.rdata));
          end
        end
        if (bus_b.gnt != 4'b0000) begin
          if (qb.size() == 0) begin
            chk("unexpected_gnt_b", 32'(bus_b.gnt), 32'h0);
          end else begin
            e = qb.pop_front();
            chk("gnt_b",   32'(bus_b.gnt),   32'(e.gnt));
            chk("rdata_b", 32'(bus_b.rdata), 32'(e.rdata));
          end
        end
        chk("busy_a", 32'(bus_a.busy), 32'h0);
        if (bchk_b) chk("busy_b", 32'(bus_b.busy), 32'(ebusy_b));
        if (done || ncyc > 2000) begin
          if (!done) chk("timeout", 32'(ncyc), 32'h0);
          chk("missing_gnt_a", 32'(qa.size()), 32'h0);
          chk("missing_gnt_b", 32'(qb.size()), 32'h0);
          $display("test done: total=%0d bad=%0d", total, bad);
          $finish;
        end
      end
    end
  end

  // Stimulus: directed vectors, expected grants pushed as they are requested.
  initial begin : stim
    bus_a.req = '0; bus_a.seed_load = 1'b0; bus_a.seed = '0;
    bus_b.req = '0; bus_b.seed_load = 1'b0; bus_b.seed = '0;
    #1;
    pulse_reset();

    // Single req[0] pulse, then a held req[0] streams the PRBS sequence.
    bus_a.req = 4'b0001; push_a(4'b0001, 8'h01);
    cyc();
    bus_a.req = 4'b0000;
    cyc();
    bus_a.req = 4'b0001;
    push_a(4'b0001, 8'h02); push_a(4'b0001, 8'h04); push_a(4'b0001, 8'h08);
    push_a(4'b0001, 8'h11); push_a(4'b0001, 8'h23);
    repeat (5) cyc();
    bus_a.req = 4'b0000;
    cyc();

    // Zero seed with a request in the same cycle: seed wins, lockup guard gives 01.
    bus_a.seed_load = 1'b1; bus_a.seed = 8'h00; bus_a.req = 4'b0010;
    cyc();
    bus_a.seed_load = 1'b0; push_a(4'b0010, 8'h01);
    cyc();
    bus_a.req = 4'b0000;
    cyc();

    // STEPS=8 streaming to req[2]: one grant per 8 cycles, busy high for 7 of them.
    bchk_b = 1'b1; ebusy_b = 1'b0;
    bus_b.req = 4'b0100;
    push_b(4'b0100, 8'h01); push_b(4'b0100, 8'h1C);
    push_b(4'b0100, 8'h4B); push_b(4'b0100, 8'h81);
    for (int k = 0; k < 32; k++) begin
      cyc();
      ebusy_b = ((k % 8) != 7);
      if (k == 24) bus_b.req = 4'b0000;
    end
    cyc();

    // Reseed while stepping (count=4): stepping aborts, next grant carries the seed.
    bus_b.req = 4'b0001; push_b(4'b0001, 8'h92);
    cyc();
    bus_b.req = 4'b0000; ebusy_b = 1'b1;
    cyc();
    cyc();
    cyc();
    bus_b.seed_load = 1'b1; bus_b.seed = 8'hA5;
    cyc();
    bus_b.seed_load = 1'b0; ebusy_b = 1'b0;
    bus_b.req = 4'b0001; push_b(4'b0001, 8'hA5);
    cyc();
    bus_b.req = 4'b0000; ebusy_b = 1'b1;
    cyc();
    cyc();

    // Reset while dut_b steps and dut_a has a grant just issued (never seen).
    bus_a.req = 4'b0001;
    cyc();
    bus_a.req = 4'b0000; ebusy_b = 1'b0;
    pulse_reset();

    // After reset: pointer back to 0 and PRBS back to SEED_RST; round robin on dut_a.
    bus_b.req = 4'b0011; push_b(4'b0001, 8'h01);
    bus_a.req = 4'b1111;
    push_a(4'b0001, 8'h01); push_a(4'b0010, 8'h02); push_a(4'b0100, 8'h04);
    push_a(4'b1000, 8'h08); push_a(4'b0001, 8'h11);
    for (int k = 0; k < 10; k++) begin
      cyc();
      ebusy_b = (k < 7);
      if (k == 0) bus_b.req = 4'b0000;
      if (k == 4) bus_a.req = 4'b0000;
    end
    done = 1'b1;
  end

endmodule
